// File: rtl/exu_wb_sched.sv
// ---------------------------------------------------------------------------
// exu_wb_sched -- execute-stage issue and writeback scheduler.
//
// Accepts decoded ops. Single-cycle ALU results go straight to the register
// file write port. A multi-cycle op (mul/div) is sequenced with a start/done
// handshake. While that op is in flight, its destination register is tracked
// and any issue that touches it is blocked. The single writeback port is
// shared by the two result sources, and a multi-cycle completion always owns
// it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   issue_valid / issue_ready   op handshake (issue_ready is combinational)
//   issue_mc, issue_wen         op is multi-cycle / op writes a register
//   issue_rd, issue_rs1/rs2     destination and source register addresses
//   sc_result                   single-cycle result, valid in the issue cycle
//   mc_start, mc_kill           one-cycle start / abort pulses to the mc unit
//   mc_done, mc_result          mc unit completion pulse and its result
//   lsu_stall                   freezes issue and new writebacks
//   flush                       pipeline flush, aborts any in-flight mc op
//   wb_en, wb_addr, wb_data     register file write port (registered)
//   busy                        multi-cycle op in flight
//   hazard                      issue blocked by the pending destination
// ---------------------------------------------------------------------------
module exu_wb_sched #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            issue_mc,
    input  logic            issue_wen,
    input  logic [RW-1:0]   issue_rd,
    input  logic [RW-1:0]   issue_rs1,
    input  logic [RW-1:0]   issue_rs2,
    input  logic [XLEN-1:0] sc_result,
    output logic            mc_start,
    output logic            mc_kill,
    input  logic            mc_done,
    input  logic [XLEN-1:0] mc_result,
    input  logic            lsu_stall,
    input  logic            flush,
    output logic            wb_en,
    output logic [RW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            hazard
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   pend_rd;
    logic            pend_wen;
    logic [XLEN-1:0] buf_data;

    logic            accept;
    logic            pend_writes;
    logic            wr_en_nxt;
    logic [RW-1:0]   wr_addr_nxt;
    logic [XLEN-1:0] wr_data_nxt;

    assign busy        = (state != IDLE);
    assign pend_writes = pend_wen && (pend_rd != '0);

    // An in-flight mc op blocks any op that reads or overwrites its destination.
    assign hazard = busy && pend_writes && issue_valid &&
                    ((issue_rs1 == pend_rd) || (issue_rs2 == pend_rd) ||
                     (issue_rd == pend_rd));

    // Single-cycle ops may issue underneath an in-flight mc op. They may not
    // issue in the cycle its result arrives, because that result needs the
    // write port.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue_ready = 1'b0;
        if (!lsu_stall && !flush) begin
            case (state)
                IDLE:        issue_ready = 1'b1;
                START, WAIT: issue_ready = !issue_mc && !hazard && !mc_done;
                default:     issue_ready = 1'b0;
            endcase
        end
    end

    assign accept = issue_valid && issue_ready;

    // Next-cycle write. At most one source is active: an accept in WAIT
    // requires ~mc_done, and DONE never accepts. The address and data are
    // zeroed whenever no write takes place.
    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = '0;
        wr_data_nxt = '0;
        if (accept && !issue_mc) begin
            if (issue_wen && (issue_rd != '0)) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = issue_rd;
                wr_data_nxt = sc_result;
            end
        end else if (!flush && !lsu_stall && pend_writes) begin
            if (state == WAIT && mc_done) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = pend_rd;
                wr_data_nxt = mc_result;
            end else if (state == DONE) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = pend_rd;
                wr_data_nxt = buf_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_rd  <= '0;
            pend_wen <= 1'b0;
            // NOTE: the result buffer is reset along with the control state,
            // so it never holds stale data from before the reset.
            buf_data <= '0;
            mc_start <= 1'b0;
            mc_kill  <= 1'b0;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            mc_start <= 1'b0;
            mc_kill  <= 1'b0;
            wb_en    <= wr_en_nxt;
            wb_addr  <= wr_addr_nxt;
            wb_data  <= wr_data_nxt;

            if (flush) begin
                // Abort the mc unit only if it has something to abort.
                mc_kill  <= busy;
                state    <= IDLE;
                pend_rd  <= '0;
                pend_wen <= 1'b0;
                buf_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && issue_mc) begin
                            pend_rd  <= issue_rd;
                            pend_wen <= issue_wen;
                            mc_start <= 1'b1;   // high exactly while in START
                            state    <= START;
                        end
                    end
                    START: state <= WAIT;
                    WAIT: begin
                        if (mc_done) begin
                            if (lsu_stall) begin
                                buf_data <= mc_result;
                                state    <= DONE;
                            end else begin
                                pend_rd  <= '0;
                                pend_wen <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    DONE: begin
                        if (!lsu_stall) begin
                            pend_rd  <= '0;
                            pend_wen <= 1'b0;
                            buf_data <= '0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_exu_wb_sched -- directed self-checking bench for exu_wb_sched.
// Inputs change 2 ns after each rising edge. Outputs are checked 1 ns later,
// which keeps every sample clear of the active edge.
// ---------------------------------------------------------------------------
module tb_exu_wb_sched;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic            issue_mc;
    logic            issue_wen;
    logic [RW-1:0]   issue_rd;
    logic [RW-1:0]   issue_rs1;
    logic [RW-1:0]   issue_rs2;
    logic [XLEN-1:0] sc_result;
    logic            mc_start;
    logic            mc_kill;
    logic            mc_done;
    logic [XLEN-1:0] mc_result;
    logic            lsu_stall;
    logic            flush;
    logic            wb_en;
    logic [RW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            hazard;

    int checks = 0;
    int errors = 0;

    exu_wb_sched #(.XLEN(XLEN), .RW(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_mc    (issue_mc),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .sc_result   (sc_result),
        .mc_start    (mc_start),
        .mc_kill     (mc_kill),
        .mc_done     (mc_done),
        .mc_result   (mc_result),
        .lsu_stall   (lsu_stall),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_mc    = 1'b0;
        issue_wen   = 1'b0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        sc_result   = '0;
        mc_done     = 1'b0;
        mc_result   = '0;
        lsu_stall   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic issue(input logic mc, input logic wen, input logic [RW-1:0] rd,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [XLEN-1:0] res);
        issue_valid = 1'b1;
        issue_mc    = mc;
        issue_wen   = wen;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        sc_result   = res;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [RW-1:0] addr,
                            input logic [XLEN-1:0] data);
        check({tag, "_en"},   64'(wb_en),   64'(en));
        check({tag, "_addr"}, 64'(wb_addr), 64'(addr));
        check({tag, "_data"}, wb_data,      data);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        check_wb("rst_wb", 1'b0, 5'd0, 64'h0);
        check("rst_mc_start", 64'(mc_start), 64'd0);
        check("rst_mc_kill",  64'(mc_kill),  64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_hazard",   64'(hazard),   64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle op, 1-cycle latency, 1-cycle pulse
        issue(1'b0, 1'b1, 5'd5, 5'd1, 5'd2, 64'h1234);
        #1 check("sc_ready", 64'(issue_ready), 64'd1);
        tick();
        idle_inputs();
        check_wb("sc_wb", 1'b1, 5'd5, 64'h1234);
        tick();
        check_wb("sc_wb_after", 1'b0, 5'd0, 64'h0);

        // rd==0 never writes, and the data stays 0
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 64'hFFFF);
        tick();
        idle_inputs();
        check_wb("rd0_wb", 1'b0, 5'd0, 64'h0);

        // mc_done outside WAIT is ignored
        mc_done   = 1'b1;
        mc_result = 64'hAAAA;
        tick();
        idle_inputs();
        check_wb("stray_done_wb", 1'b0, 5'd0, 64'h0);
        check("stray_done_busy", 64'(busy), 64'd0);

        // Multi-cycle op with done 4 cycles after mc_start
        issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 64'h0);
        #1 check("mc_ready", 64'(issue_ready), 64'd1);
        tick();
        idle_inputs();
        check("mc_start_pulse", 64'(mc_start), 64'd1);
        check("mc_busy_start",  64'(busy),     64'd1);
        tick();
        check("mc_start_low",   64'(mc_start), 64'd0);
        check("mc_busy_wait",   64'(busy),     64'd1);
        tick();
        tick();
        tick();
        mc_done   = 1'b1;
        mc_result = 64'hDEAD;
        #1 check("mc_no_early_wb", 64'(wb_en), 64'd0);
        tick();
        idle_inputs();
        check_wb("mc_wb", 1'b1, 5'd7, 64'hDEAD);
        check("mc_idle_after", 64'(busy), 64'd0);
        tick();
        check_wb("mc_wb_after", 1'b0, 5'd0, 64'h0);

        // Hazard and overlap
        issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 64'h0);
        tick();
        issue(1'b0, 1'b1, 5'd4, 5'd7, 5'd0, 64'h55);
        #1 check("haz_rs1",       64'(hazard),      64'd1);
        check("haz_rs1_ready",    64'(issue_ready), 64'd0);
        issue(1'b0, 1'b1, 5'd4, 5'd0, 5'd7, 64'h55);
        #1 check("haz_rs2",       64'(hazard),      64'd1);
        issue(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 64'h55);
        #1 check("haz_rd",        64'(hazard),      64'd1);
        issue(1'b1, 1'b1, 5'd20, 5'd0, 5'd0, 64'h0);
        #1 check("busy_mc_ready", 64'(issue_ready), 64'd0);
        issue(1'b0, 1'b1, 5'd4, 5'd3, 5'd0, 64'h55);
        #1 check("nohaz",         64'(hazard),      64'd0);
        check("nohaz_ready",      64'(issue_ready), 64'd1);
        tick();
        idle_inputs();
        check_wb("overlap_wb", 1'b1, 5'd4, 64'h55);
        check("overlap_busy", 64'(busy), 64'd1);
        tick();

        // Collision: mc_done together with a valid single-cycle issue
        issue(1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 64'h99);
        mc_done   = 1'b1;
        mc_result = 64'hBEEF;
        #1 check("coll_ready", 64'(issue_ready), 64'd0);
        tick();
        mc_done = 1'b0;
        #1 check_wb("coll_mc_wb", 1'b1, 5'd7, 64'hBEEF);
        check("coll_ready_idle", 64'(issue_ready), 64'd1);
        tick();
        idle_inputs();
        check_wb("coll_sc_wb", 1'b1, 5'd9, 64'h99);
        tick();
        check_wb("coll_after", 1'b0, 5'd0, 64'h0);

        // Stall at completion: buffered, written 1 cycle after the stall drops
        issue(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 64'h0);
        tick();
        idle_inputs();
        tick();
        mc_done   = 1'b1;
        mc_result = 64'hCAFE;
        lsu_stall = 1'b1;
        #1 check("stall_ready", 64'(issue_ready), 64'd0);
        tick();
        mc_done = 1'b0;
        check("stall_done_wb", 64'(wb_en), 64'd0);
        check("stall_busy",    64'(busy),  64'd1);
        tick();
        check("stall_done_wb2", 64'(wb_en), 64'd0);
        tick();
        lsu_stall = 1'b0;
        issue(1'b0, 1'b1, 5'd13, 5'd0, 5'd0, 64'h13);
        #1 check("done_ready", 64'(issue_ready), 64'd0);
        check("done_wb_none", 64'(wb_en), 64'd0);
        tick();
        idle_inputs();
        check_wb("buf_wb", 1'b1, 5'd10, 64'hCAFE);
        check("buf_idle", 64'(busy), 64'd0);
        tick();
        check_wb("buf_after", 1'b0, 5'd0, 64'h0);

        // Flush in WAIT
        issue(1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 64'h0);
        tick();
        idle_inputs();
        tick();
        flush = 1'b1;
        issue(1'b0, 1'b1, 5'd14, 5'd0, 5'd0, 64'h14);
        #1 check("flush_ready", 64'(issue_ready), 64'd0);
        check("flush_kill_pre", 64'(mc_kill), 64'd0);
        tick();
        idle_inputs();
        check("flush_kill", 64'(mc_kill), 64'd1);
        check("flush_busy", 64'(busy),    64'd0);
        check_wb("flush_wb", 1'b0, 5'd0, 64'h0);
        tick();
        check("flush_kill_once", 64'(mc_kill), 64'd0);
        mc_done   = 1'b1;
        mc_result = 64'h7777;
        tick();
        idle_inputs();
        check("late_done_wb", 64'(wb_en), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush_kill", 64'(mc_kill), 64'd0);

        // Asynchronous reset mid-operation, while a write is on the port
        issue(1'b1, 1'b1, 5'd12, 5'd0, 5'd0, 64'h0);
        tick();
        issue(1'b0, 1'b1, 5'd6, 5'd0, 5'd0, 64'h66);
        tick();
        idle_inputs();
        check_wb("pre_rst_wb", 1'b1, 5'd6, 64'h66);
        rst_n = 1'b0;
        #1 check_wb("async_rst_wb", 1'b0, 5'd0, 64'h0);
        check("async_rst_busy",  64'(busy),     64'd0);
        check("async_rst_start", 64'(mc_start), 64'd0);
        tick();
        check("rst_no_kill", 64'(mc_kill), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
